hzd_scoreboard: RTL and testbench

- Parametrised successor to the combinational hazard detector in the 5-stage pipeline; sits beside the F/D and D/X pipeline registers.
- Replaces fixed-stage operand compares with a per-register countdown scoreboard, so loads and multi-cycle ops of any latency stall correctly.
- Adds a branch-flush state machine and a saturating stall counter.
- Drives bubble (D/X zero-insert), F/D write enable and PC write enable.

---
 rtl/hzd_pkg.sv | 7 +
 rtl/hzd_sb_entry.sv | 14 +
 rtl/hzd_scoreboard.sv | 82 ++++++++
 tb/tb_hzd_scoreboard.sv | 133 +++++++++++++
 4 files changed

// File: rtl/hzd_pkg.sv
// hzd_pkg: shared defaults, FSM state type and decoder load latency for the hazard scoreboard
package hzd_pkg;
  localparam int REG_ADDR_W_DEF = 4;
  localparam int LAT_W_DEF = 3;
  localparam int LOAD_LAT = 1;
  typedef enum logic {ST_RUN, ST_FLUSH} st_t;
endpackage

// File: rtl/hzd_sb_entry.sv
// hzd_sb_entry: one scoreboard latency countdown (clk, rst_n, ld, ld_val in; cnt out), load beats decrement
module hzd_sb_entry #(
  parameter int LAT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [LAT_W-1:0] ld_val,
  output logic [LAT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= ld ? ld_val : (cnt != '0 ? cnt - 1'b1 : cnt);
endmodule

// File: rtl/hzd_scoreboard.sv
// hzd_scoreboard: countdown-scoreboard hazard detector with branch flush FSM and stall counter; issue_* loads the scoreboard, src*/branch_op checked for hazards, drives bubble/f_d_write/pc_write/flush/stall_cnt; HZD_R0_ZERO_EN makes r0 hardwired zero
module hzd_scoreboard
  import hzd_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int LAT_W = LAT_W_DEF,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  issue_valid,
  input  logic                  issue_wr,
  input  logic [REG_ADDR_W-1:0] issue_dst,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [REG_ADDR_W-1:0] src1,
  input  logic [REG_ADDR_W-1:0] src2,
  input  logic                  src1_used,
  input  logic                  src2_used,
  input  logic                  branch_op,
  input  logic                  branch_taken,
  output logic                  bubble,
  output logic                  f_d_write,
  output logic                  pc_write,
  output logic                  flush,
  output logic [CNT_W-1:0]      stall_cnt
);
  localparam int NUM_REGS = 2**REG_ADDR_W;
  logic [LAT_W-1:0] cnt [NUM_REGS];
  logic last_wr;
  logic [REG_ADDR_W-1:0] last_dst;
  st_t state;
  logic [3:0] fcnt;
  logic wr_ok, s1_ok, s2_ok, acc, data_haz, br_haz, stall;
`ifdef HZD_R0_ZERO_EN
  assign wr_ok = issue_dst != '0;
  assign s1_ok = src1_used & (src1 != '0);
  assign s2_ok = src2_used & (src2 != '0);
`else
  assign wr_ok = 1'b1;
  assign s1_ok = src1_used;
  assign s2_ok = src2_used;
`endif
  assign acc = issue_valid & issue_wr & !bubble & !flush & wr_ok;
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
    hzd_sb_entry #(.LAT_W(LAT_W)) u_entry (
      .clk(clk),
      .rst_n(rst_n),
      .ld(acc && issue_dst == REG_ADDR_W'(i)),
      .ld_val(issue_lat),
      .cnt(cnt[i])
    );
  end
  assign data_haz = (s1_ok & (cnt[src1] != '0)) | (s2_ok & (cnt[src2] != '0));
  // a latency-0 result reaches X by forwarding but is not yet visible to a branch resolving in D
  assign br_haz = branch_op & last_wr & ((s1_ok & (src1 == last_dst)) | (s2_ok & (src2 == last_dst)));
  assign stall = data_haz | br_haz;
  assign flush = state == ST_FLUSH;
  assign bubble = flush | stall;
  assign f_d_write = flush | !stall;
  assign pc_write = flush | !stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_wr <= 1'b0;
      last_dst <= '0;
      state <= ST_RUN;
      fcnt <= '0;
      stall_cnt <= '0;
    end else begin
      last_wr <= acc;
      if (acc) last_dst <= issue_dst;
      if (state == ST_RUN) begin
        if (stall && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
        if (branch_taken && !stall) begin
          state <= ST_FLUSH;
          fcnt <= 4'(FLUSH_CYCLES - 1);
        end
      end else if (branch_taken) fcnt <= 4'(FLUSH_CYCLES - 1);
      else if (fcnt == '0) state <= ST_RUN;
      else fcnt <= fcnt - 1'b1;
    end
endmodule

// File: tb/tb_hzd_scoreboard.sv
// tb_hzd_scoreboard: directed scoreboard-queue bench for hzd_scoreboard
module tb_hzd_scoreboard;
  import hzd_pkg::*;
  logic clk = 0, rst_n = 0;
  logic issue_valid, issue_wr, src1_used, src2_used, branch_op, branch_taken;
  logic [3:0] issue_dst, src1, src2;
  logic [2:0] issue_lat;
  logic bubble, f_d_write, pc_write, flush;
  logic [15:0] stall_cnt;
  int errors = 0, checks = 0;
  typedef struct {string tag; logic [3:0] v;} exp_t;
  exp_t q[$];
  logic e;
  hzd_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_wr(issue_wr),
    .issue_dst(issue_dst), .issue_lat(issue_lat), .src1(src1), .src2(src2),
    .src1_used(src1_used), .src2_used(src2_used), .branch_op(branch_op),
    .branch_taken(branch_taken), .bubble(bubble), .f_d_write(f_d_write),
    .pc_write(pc_write), .flush(flush), .stall_cnt(stall_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic idle();
    issue_valid = 0; issue_wr = 0; issue_dst = 0; issue_lat = 0;
    src1 = 0; src2 = 0; src1_used = 0; src2_used = 0; branch_op = 0; branch_taken = 0;
  endtask
  task automatic issue(input logic [3:0] d, input logic [2:0] l);
    issue_valid = 1; issue_wr = 1; issue_dst = d; issue_lat = l;
  endtask
  // eb: bubble expected, ef: flush expected; enables are low only on a hazard stall
  task automatic cyc(input string tag, input logic eb, input logic ef);
    exp_t x;
    q.push_back('{tag, {eb, ef, ef | !eb, ef | !eb}});
    #1;
    x = q.pop_front();
    checks++;
    assert ({bubble, flush, f_d_write, pc_write} === x.v) else begin
      errors++;
      $error("FAIL %s {bubble,flush,f_d_write,pc_write} got %b exp %b", x.tag, {bubble, flush, f_d_write, pc_write}, x.v);
    end
    @(negedge clk);
    idle();
  endtask
  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    checks++;
    assert (stall_cnt === exp) else begin
      errors++;
      $error("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, exp);
    end
  endtask
  initial begin
    idle();
    src1 = 1; src2 = 2; src1_used = 1; src2_used = 1;
    #3;
    chk_cnt("rst_cnt", 0);
    cyc("rst", 0, 0);
    rst_n = 1;
    src1 = 1; src2 = 2; src1_used = 1; src2_used = 1;
    cyc("idle", 0, 0);
    issue(3, 2);
    cyc("iss3", 0, 0);
    src1 = 3; src1_used = 1;
    cyc("haz3a", 1, 0);
    src1 = 3; src1_used = 1;
    cyc("haz3b", 1, 0);
    src1 = 3; src1_used = 1;
    cyc("haz3c", 0, 0);
    chk_cnt("cnt_after3", 2);
    issue(5, 0);
    cyc("iss5", 0, 0);
    branch_op = 1; src1 = 5; src1_used = 1;
    cyc("br5a", 1, 0);
    branch_op = 1; src1 = 5; src1_used = 1;
    cyc("br5b", 0, 0);
    issue(5, 0);
    cyc("iss5b", 0, 0);
    src1 = 5; src1_used = 1;
    cyc("nobr5", 0, 0);
    chk_cnt("cnt_after5", 3);
    branch_taken = 1;
    cyc("bt1", 0, 0);
    cyc("fl1", 1, 1);
    cyc("fl2", 1, 1);
    cyc("fl_end", 0, 0);
    branch_taken = 1;
    cyc("bt2", 0, 0);
    branch_taken = 1;
    cyc("fl1b", 1, 1);
    issue(6, 3);
    cyc("fl2b", 1, 1);
    cyc("fl3b", 1, 1);
    src1 = 6; src1_used = 1;
    cyc("fl_iss_drop", 0, 0);
    chk_cnt("cnt_flush", 3);
    issue(7, LOAD_LAT);
    cyc("iss7", 0, 0);
    src1 = 7; src1_used = 1; branch_taken = 1;
    cyc("bt_stall", 1, 0);
    cyc("bt_ignored", 0, 0);
    chk_cnt("cnt_bt_stall", 4);
    issue(3, 2);
    cyc("iss3r", 0, 0);
    src1 = 3; src1_used = 1;
    cyc("pre_rst", 1, 0);
    src1 = 3; src1_used = 1;
    #2 rst_n = 0;
    cyc("mid_rst", 0, 0);
    chk_cnt("cnt_mid_rst", 0);
    rst_n = 1;
    src1 = 3; src1_used = 1;
    cyc("post_rst", 0, 0);
    issue(0, 3);
    cyc("iss0", 0, 0);
`ifdef HZD_R0_ZERO_EN
    e = 0;
`else
    e = 1;
`endif
    for (int i = 0; i < 3; i++) begin
      src1 = 0; src1_used = 1;
      cyc("r0_haz", e, 0);
    end
    src1 = 0; src1_used = 1;
    cyc("r0_done", 0, 0);
    chk_cnt("cnt_r0", e ? 16'd3 : 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
